instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/tinyalu_pkg.sv | 32 +++
 rtl/seq_watchdog.sv | 28 ++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tinyalu_pkg.sv
// Shared definitions for the tinyalu instruction path: instruction word layout,
// opcode encoding and the sequencer state machine encoding.
package tinyalu_pkg;

  localparam int INSTR_W  = 19;
  localparam int OPC_HI   = 18;
  localparam int OPC_LO   = 15;
  localparam int ADDR_HI  = 14;
  localparam int ADDR_LO  = 1;
  localparam int RSEL_BIT = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_AND  = 4'h2,
    OP_XOR  = 4'h3,
    OP_MUL  = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_HALT = 4'hF
  } alu_opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RD,
    S_ISSUE,
    S_WAIT_DONE,
    S_ERROR
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle counter guarding the wait for instruction completion.
// expired flags the cycle whose increment would make the count reach TIMEOUT.
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Combinational so the sequencer can leave WAIT_DONE on the exact cycle
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetches a program from instruction memory one word at a time, hands each word
// to the instruction unit and waits for its completion before moving on.
module instr_sequencer
  import tinyalu_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [PC_W-1:0]      prog_len,
  output logic [PC_W-1:0]      imem_addr,
  output logic                 imem_rd,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic                 issue,
  output logic [INSTR_W-1:0]   issue_instr,
  input  logic                 exec_done,
  output logic                 busy,
  output logic                 finished,
  output logic                 error,
  output logic [PC_W:0]        retired
);

  seq_state_t      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] prog_len_q;
  logic            last_instr;
  logic            is_halt;
  logic            wd_expired;
  alu_opcode_t     cur_op;

  assign pc_inc     = pc + PC_W'(1);
  assign last_instr = ({1'b0, pc} + (PC_W+1)'(1)) == {1'b0, prog_len_q};
  assign cur_op     = alu_opcode_t'(issue_instr[OPC_HI:OPC_LO]);
  assign is_halt    = (cur_op == OP_HALT);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == S_ISSUE),
    .enable  ((state == S_WAIT_DONE) && !exec_done),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      prog_len_q  <= '0;
      imem_addr   <= '0;
      imem_rd     <= 1'b0;
      issue       <= 1'b0;
      issue_instr <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      error       <= 1'b0;
      retired     <= '0;
    end else begin
      finished <= 1'b0;
      imem_rd  <= 1'b0;
      issue    <= 1'b0;
      case (state)
        S_IDLE, S_ERROR: begin
          if (go) begin
            error   <= 1'b0;
            retired <= '0;
            if (prog_len != '0) begin
              state      <= S_FETCH;
              pc         <= '0;
              prog_len_q <= prog_len;
              imem_addr  <= '0;
              imem_rd    <= 1'b1;
              busy       <= 1'b1;
            end else begin
              // Empty program completes immediately without touching memory
              state    <= S_IDLE;
              finished <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          issue_instr <= imem_data;
          issue       <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // Completion beats the watchdog when both land on the same cycle
          if (exec_done) begin
            retired <= retired + (PC_W+1)'(1);
            if (last_instr || is_halt) begin
              state    <= S_IDLE;
              finished <= 1'b1;
              busy     <= 1'b0;
            end else begin
              pc        <= pc_inc;
              imem_addr <= pc_inc;
              imem_rd   <= 1'b1;
              state     <= S_FETCH;
            end
          end else if (wd_expired) begin
            state <= S_ERROR;
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
